spi_ram_slave_p: RTL and testbench
==================================

// Module: spi_ram_slave_p
// PURPOSE
//   Parametrised SPI slave fronting a single-port RAM; next generation of our 8-bit spi_ram.
//   Decodes 2-bit command frames shifted in on mosi (one bit per clk while ss_n low).
//   Supports write-address, write-data, read-address and read-data; read data is shifted out on miso.
//   Adds generic address/data widths, a depth check, an error flag and optional auto-increment.
// PARAMETERS
//   ADDR_WIDTH  8    address payload bits.
//   DATA_WIDTH  8    data payload bits; RAM word width.
//   MEM_DEPTH   256  RAM words; must be <= 2**ADDR_WIDTH.
// PORTS
//   clk        in   1  single clock; also the SPI bit clock; all logic on posedge.
//   rst_n      in   1  asynchronous, active-low reset.
//   ss_n       in   1  slave select, active low; frames bounded by ss_n low.
//   mosi       in   1  serial in, MSB first, sampled on posedge clk.
//   miso       out  1  serial out, registered, MSB first.
//   tx_active  out  1  high while read data is being shifted out on miso.
//   frame_err  out  1  one-cycle pulse on a rejected frame.
// BEHAVIOUR
//   Reset values: miso=0, tx_active=0, frame_err=0, state=IDLE, wr_addr=0, rd_addr=0, rd_addr_valid=0.
//   RAM contents are not reset.
//   Frame format: cmd[1] cmd[0] payload; all bits MSB first.
//     00 = write address (ADDR_WIDTH bits).
//     01 = write data (DATA_WIDTH bits).
//     10 = read address (ADDR_WIDTH bits).
//     11 = read data (DATA_WIDTH dummy bits, then DATA_WIDTH bits out on miso).
//   States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//   IDLE: on the edge ss_n is sampled low -> CHK_CMD. The first mosi bit is sampled on the next edge.
//   CHK_CMD: samples cmd[1].
//     cmd[1]=0 -> WRITE.
//     cmd[1]=1 and rd_addr_valid=1 -> READ_DATA.
//     cmd[1]=1 and rd_addr_valid=0 -> READ_ADD.
//   WRITE/READ_ADD/READ_DATA: shift cmd[0] then the payload.
//     Payload length is chosen by cmd[0].
//     Commit happens on the edge that samples the last payload bit.
//   Commit actions:
//     00: wr_addr <= payload.
//     01: mem[wr_addr] <= payload.
//     10: rd_addr <= payload; rd_addr_valid <= 1. Allowed in READ_DATA state too (reloads the address).
//   11 in READ_DATA: after the last dummy bit at edge E, mem[rd_addr] is loaded into tx_reg at E+1.
//     miso carries bits MSB..LSB on edges E+2 .. E+1+DATA_WIDTH.
//     tx_active is high over the same edges.
//     rd_addr_valid clears after the last bit; miso returns to 0.
//   11 in READ_ADD (no valid read address): frame rejected.
//     frame_err=1 for one cycle at the commit edge; no RAM access; miso stays 0.
//   Out-of-range address (>= MEM_DEPTH):
//     data write is dropped and frame_err pulses.
//     data read shifts out all zeros and frame_err pulses.
//   Surplus bits after commit are ignored until ss_n rises.
//   ss_n high in any state -> IDLE on the next edge.
//     A partial frame is discarded with no commit and no frame_err.
//     An in-progress miso shift is aborted: miso=0, tx_active=0, rd_addr_valid unchanged.
//   rst_n low mid-frame: immediate return to reset values; wr_addr and rd_addr are lost.
// CONFIGURATION
//   SPI_RAM_AUTOINC_EN defined:
//     after each committed data write, wr_addr <= wr_addr+1.
//     after each completed data read, rd_addr <= rd_addr+1 and rd_addr_valid stays 1.
//     Both wrap from MEM_DEPTH-1 to 0.
//   SPI_RAM_AUTOINC_EN undefined: addresses are held; rd_addr_valid clears after each read, as above.
// TESTING
//   1. Defaults. Send 00 FF, 01 FF, 10 FF, 11 00 -> miso shifts 8'hFF. tx_active high for 8 cycles.
//   2. Send 00 F0, 01 01, 10 F0, 11 00 -> miso shifts 8'h01. mem[F0]=01.
//   3. After reset, send 11 00 -> frame_err pulses once; miso stays 0; RAM unchanged.
//   4. Raise ss_n after 4 payload bits of 00 xx -> wr_addr unchanged.
//      A following 01 AA writes to the previous address.
//   5. MEM_DEPTH=200: send 00 C8, 01 55 -> frame_err pulses and no write.
//      Then 10 C8, 11 00 -> miso shifts 00 and frame_err pulses.
//   6. With SPI_RAM_AUTOINC_EN: send 00 FF, 01 11, 01 22 -> mem[FF]=11, mem[00]=22 (wrap).
//      Then 10 FF, 11 00, 11 00 -> miso shifts 11 then 22.

Source files
------------

// File: rtl/spi_ram_slave_p.sv
// SPI slave (one bit per clk while ss_n low) fronting a single-port RAM with
// write/read address and data commands. Optional address auto-increment: SPI_RAM_AUTOINC_EN.
module spi_ram_slave_p #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic tx_active,
    output logic frame_err
);

    // state     | meaning
    // IDLE      | waiting for ss_n low
    // CHK_CMD   | sampling cmd[1]
    // WRITE     | cmd[0] + payload of a write-address / write-data frame
    // READ_ADD  | read frame with no valid read address
    // READ_DATA | read frame with a valid read address; also drives miso shift-out
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam int TW = $clog2(DATA_WIDTH + 1);
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CW-1:0] ALEN = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DLEN = CW'(DATA_WIDTH);
    localparam logic [TW-1:0] TLEN = TW'(DATA_WIDTH);

    state_t                  state_q, state_d;
    logic                    first_q, first_d;
    logic                    done_q, done_d;
    logic                    cmd0_q, cmd0_d;
    logic [CW-1:0]           rem_q, rem_d;
    logic [SW-1:0]           shift_q, shift_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    rd_addr_valid_q, rd_addr_valid_d;
    logic                    load_pend_q, load_pend_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [TW-1:0]           tx_cnt_q, tx_cnt_d;
    logic                    tx_active_q, tx_active_d;
    logic                    miso_q, miso_d;
    logic                    frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    mem_we;
    logic [MW-1:0]           mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    wr_ok, rd_ok;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < MEM_DEPTH;
    endfunction

`ifdef SPI_RAM_AUTOINC_EN
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) >= MEM_DEPTH - 1) ? '0 : a + ADDR_WIDTH'(1);
    endfunction
`endif

    assign wr_ok     = addr_ok(wr_addr_q);
    assign rd_ok     = addr_ok(rd_addr_q);
    assign mem_waddr = wr_addr_q[MW-1:0];

    always_comb begin
        state_d         = state_q;
        first_d         = first_q;
        done_d          = done_q;
        cmd0_d          = cmd0_q;
        rem_d           = rem_q;
        shift_d         = {shift_q[SW-2:0], mosi};
        wr_addr_d       = wr_addr_q;
        rd_addr_d       = rd_addr_q;
        rd_addr_valid_d = rd_addr_valid_q;
        load_pend_d     = load_pend_q;
        tx_shift_d      = tx_shift_q;
        tx_cnt_d        = tx_cnt_q;
        tx_active_d     = tx_active_q;
        miso_d          = miso_q;
        frame_err_d     = 1'b0;
        mem_we          = 1'b0;
        mem_wdata       = shift_d[DATA_WIDTH-1:0];

        if (ss_n) begin
            // Deselect discards any partial frame and aborts a shift-out.
            state_d     = IDLE;
            first_d     = 1'b0;
            done_d      = 1'b0;
            load_pend_d = 1'b0;
            tx_cnt_d    = '0;
            tx_active_d = 1'b0;
            miso_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    first_d = 1'b1;
                    done_d  = 1'b0;
                    if (!mosi)                state_d = WRITE;
                    else if (rd_addr_valid_q) state_d = READ_DATA;
                    else                      state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (first_q) begin
                        first_d = 1'b0;
                        cmd0_d  = mosi;
                        rem_d   = mosi ? DLEN : ALEN;
                    end else if (!done_q) begin
                        rem_d = rem_q - CW'(1);
                        if (rem_q == CW'(1)) begin
                            done_d = 1'b1;
                            if (state_q == WRITE) begin
                                if (!cmd0_q) begin
                                    wr_addr_d = shift_d[ADDR_WIDTH-1:0];
                                end else if (wr_ok) begin
                                    mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                                    wr_addr_d = addr_inc(wr_addr_q);
`endif
                                end else begin
                                    frame_err_d = 1'b1;
                                end
                            end else if (!cmd0_q) begin
                                rd_addr_d       = shift_d[ADDR_WIDTH-1:0];
                                rd_addr_valid_d = 1'b1;
                            end else if (state_q == READ_ADD) begin
                                frame_err_d = 1'b1;
                            end else begin
                                load_pend_d = 1'b1;
                                frame_err_d = !rd_ok;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Shift-out pipeline: load one edge after the last dummy bit, then DATA_WIDTH bits.
            if (load_pend_q) begin
                load_pend_d = 1'b0;
                tx_shift_d  = rd_ok ? mem[rd_addr_q[MW-1:0]] : '0;
                tx_cnt_d    = TLEN;
            end else if (tx_cnt_q != '0) begin
                miso_d      = tx_shift_q[DATA_WIDTH-1];
                tx_shift_d  = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                tx_cnt_d    = tx_cnt_q - TW'(1);
                tx_active_d = 1'b1;
            end else if (tx_active_q) begin
                miso_d      = 1'b0;
                tx_active_d = 1'b0;
`ifdef SPI_RAM_AUTOINC_EN
                rd_addr_d   = addr_inc(rd_addr_q);
`else
                rd_addr_valid_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            first_q         <= 1'b0;
            done_q          <= 1'b0;
            cmd0_q          <= 1'b0;
            rem_q           <= '0;
            shift_q         <= '0;
            wr_addr_q       <= '0;
            rd_addr_q       <= '0;
            rd_addr_valid_q <= 1'b0;
            load_pend_q     <= 1'b0;
            tx_shift_q      <= '0;
            tx_cnt_q        <= '0;
            tx_active_q     <= 1'b0;
            miso_q          <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            first_q         <= first_d;
            done_q          <= done_d;
            cmd0_q          <= cmd0_d;
            rem_q           <= rem_d;
            shift_q         <= shift_d;
            wr_addr_q       <= wr_addr_d;
            rd_addr_q       <= rd_addr_d;
            rd_addr_valid_q <= rd_addr_valid_d;
            load_pend_q     <= load_pend_d;
            tx_shift_q      <= tx_shift_d;
            tx_cnt_q        <= tx_cnt_d;
            tx_active_q     <= tx_active_d;
            miso_q          <= miso_d;
            frame_err_q     <= frame_err_d;
        end
    end

    // RAM contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign miso      = miso_q;
    assign tx_active = tx_active_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Directed bench for spi_ram_slave_p: a default instance and a MEM_DEPTH=200
// instance share one SPI bus; outputs are sampled 1 time unit after each posedge.
module tb_spi_ram_slave_p;

    logic clk = 1'b0;
    logic rst_n, ss_n, mosi;
    logic miso0, txa0, err0;
    logic miso1, txa1, err1;

    always #5 clk = ~clk;

    spi_ram_slave_p dut (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
        .miso(miso0), .tx_active(txa0), .frame_err(err0)
    );

    spi_ram_slave_p #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200)) dut200 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
        .miso(miso1), .tx_active(txa1), .frame_err(err1)
    );

    int errs0, txc0, stray0, errs1, txc1, stray1;
    logic [7:0] rx0, rx1;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clk) begin
        #1;
        if (txa0) begin rx0 = {rx0[6:0], miso0}; txc0++; end
        else if (miso0) stray0++;
        if (err0) errs0++;
        if (txa1) begin rx1 = {rx1[6:0], miso1}; txc1++; end
        else if (miso1) stray1++;
        if (err1) errs1++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clear_mon();
        errs0 = 0; txc0 = 0; stray0 = 0; rx0 = '0;
        errs1 = 0; txc1 = 0; stray1 = 0; rx1 = '0;
    endtask

    task automatic frame(input logic [1:0] cmd, input logic [7:0] pl,
                         input int nbits, input int extra);
        clear_mon();
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = cmd[1];
        @(negedge clk); mosi = cmd[0];
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); mosi = pl[7-i];
        end
        repeat (extra) @(negedge clk);
        ss_n = 1'b1; mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        #2;
        check("rst_miso", int'(miso0), 0);
        check("rst_tx_active", int'(txa0), 0);
        check("rst_frame_err", int'(err0), 0);
        @(negedge clk); rst_n = 1'b1;
    endtask

    typedef struct {
        string      name;
        logic [1:0] cmd;
        logic [7:0] pl;
        int         extra;
        int         exp_err;
        int         exp_txc;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{"t1_wa",   2'b00, 8'hFF, 2,  0, 0, 8'h00};
        vt[1] = '{"t1_wd",   2'b01, 8'hFF, 2,  0, 0, 8'h00};
        vt[2] = '{"t1_ra",   2'b10, 8'hFF, 2,  0, 0, 8'h00};
        vt[3] = '{"t1_rd",   2'b11, 8'h00, 12, 0, 8, 8'hFF};
        vt[4] = '{"t2_wa",   2'b00, 8'hF0, 2,  0, 0, 8'h00};
        vt[5] = '{"t2_wd",   2'b01, 8'h01, 2,  0, 0, 8'h00};
        vt[6] = '{"t2_ra",   2'b10, 8'hF0, 2,  0, 0, 8'h00};
        vt[7] = '{"t2_rd",   2'b11, 8'h00, 12, 0, 8, 8'h01};

        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        clear_mon();
        repeat (2) @(negedge clk);
        do_reset();

        for (int k = 0; k < 8; k++) begin
            frame(vt[k].cmd, vt[k].pl, 8, vt[k].extra);
            check({vt[k].name, "_err"},   errs0, vt[k].exp_err);
            check({vt[k].name, "_txc"},   txc0, vt[k].exp_txc);
            check({vt[k].name, "_rx"},    int'(rx0), int'(vt[k].exp_rx));
            check({vt[k].name, "_stray"}, stray0, 0);
        end

        // Deselect mid shift-out: aborted, read address stays valid.
        frame(2'b10, 8'hF0, 8, 2);
        frame(2'b11, 8'h00, 8, 5);
        check("abort_txc", txc0, 3);
        check("abort_tx_active", int'(txa0), 0);
        check("abort_miso", int'(miso0), 0);
        frame(2'b11, 8'h00, 8, 12);
        check("after_abort_rx", int'(rx0), 8'h01);
        check("after_abort_txc", txc0, 8);
        check("after_abort_err", errs0, 0);

        // Read data with no valid read address after reset; RAM kept.
        do_reset();
        frame(2'b11, 8'h00, 8, 12);
        check("t3_err", errs0, 1);
        check("t3_txc", txc0, 0);
        check("t3_stray", stray0, 0);
        frame(2'b10, 8'hFF, 8, 2);
        frame(2'b11, 8'h00, 8, 12);
        check("t3_ram_kept", int'(rx0), 8'hFF);

        // Partial address frame is discarded.
        frame(2'b00, 8'h10, 8, 2);
        frame(2'b00, 8'h3C, 4, 0);
        frame(2'b01, 8'hAA, 8, 2);
        check("t4_wd_err", errs0, 0);
        frame(2'b10, 8'h10, 8, 2);
        frame(2'b11, 8'h00, 8, 12);
        check("t4_rx", int'(rx0), 8'hAA);

        // Out-of-range address on the 200-word instance.
        frame(2'b00, 8'hC8, 8, 2);
        frame(2'b01, 8'h55, 8, 2);
        check("t5_wr_err200", errs1, 1);
        check("t5_wr_err256", errs0, 0);
        frame(2'b10, 8'hC8, 8, 2);
        frame(2'b11, 8'h00, 8, 12);
        check("t5_rd_err200", errs1, 1);
        check("t5_rd_rx200", int'(rx1), 0);
        check("t5_rd_txc200", txc1, 8);
        check("t5_rd_rx256", int'(rx0), 8'h55);

        // Consecutive writes and reads at the top address.
        do_reset();
        frame(2'b00, 8'hFF, 8, 2);
        frame(2'b01, 8'h11, 8, 2);
        frame(2'b01, 8'h22, 8, 2);
        frame(2'b10, 8'hFF, 8, 2);
        frame(2'b11, 8'h00, 8, 12);
`ifdef SPI_RAM_AUTOINC_EN
        check("t6_rd1", int'(rx0), 8'h11);
`else
        check("t6_rd1", int'(rx0), 8'h22);
`endif
        frame(2'b11, 8'h00, 8, 12);
`ifdef SPI_RAM_AUTOINC_EN
        check("t6_rd2_rx", int'(rx0), 8'h22);
        check("t6_rd2_err", errs0, 0);
        check("t6_rd2_txc", txc0, 8);
`else
        check("t6_rd2_rx", int'(rx0), 0);
        check("t6_rd2_err", errs0, 1);
        check("t6_rd2_txc", txc0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
